// File: rtl/sobel_seq.sv
// Sequential 3x3 Sobel |Gx|+|Gy| custom-instruction unit: one shared {-2..2} MAC, 18 taps per compute.
// Optional SOBEL_SEQ_THRESHOLD_EN turns the saturated magnitude into a 0/255 threshold result.
module sobel_seq #(
  parameter logic [7:0] customId = 8'h19
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  ciN,
  output logic        done,
  output logic [31:0] result
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 3;
  localparam int ACC_W  = 16;

  typedef enum logic [1:0] {IDLE, MAC, FINAL, DONE} state_t;

  localparam logic [1:0] CMD_CLEAR = 2'd0;
  localparam logic [1:0] CMD_PUSH  = 2'd1;

  state_t                           state_q, state_d;
  logic [8:0][DATA_W-1:0]           win_q, win_d;
  logic signed [ACC_W-1:0]          gx_q, gx_d, gy_q, gy_d;
  logic [4:0]                       k_q, k_d;
  logic                             done_q, done_d;
  logic [31:0]                      res_q, res_d;
`ifdef SOBEL_SEQ_THRESHOLD_EN
  logic [DATA_W-1:0]                thr_q, thr_d;
`endif

  // Gx taps k=0..8, Gy taps k=9..17, both row-major over the window.
  function automatic logic signed [COEF_W-1:0] tap_coef(input logic [4:0] k);
    case (k)
      5'd0, 5'd6, 5'd9, 5'd11: tap_coef = 3'b111;
      5'd3, 5'd10:             tap_coef = 3'b110;
      5'd2, 5'd8, 5'd15, 5'd17: tap_coef = 3'b001;
      5'd5, 5'd16:             tap_coef = 3'b010;
      default:                 tap_coef = 3'b000;
    endcase
  endfunction

  function automatic logic [ACC_W-1:0] abs_acc(input logic signed [ACC_W-1:0] g);
    abs_acc = g[ACC_W-1] ? ACC_W'(-g) : ACC_W'(g);
  endfunction

  function automatic logic [DATA_W-1:0] sat_u8(input logic [ACC_W:0] m);
    sat_u8 = (m > 17'd255) ? 8'hFF : m[DATA_W-1:0];
  endfunction

  logic                     accept;
  logic [1:0]               cmd;
  logic [4:0]               pix_idx;
  logic [DATA_W-1:0]        pix;
  logic signed [COEF_W-1:0] coef;
  logic signed [ACC_W-1:0]  coef_ext, pix_ext, prod;
  logic [ACC_W:0]           mag;
  logic                     unused_ok;

  assign accept   = start && (ciN == customId) && (state_q == IDLE);
  assign cmd      = valueB[1:0];
  assign pix_idx  = (k_q < 5'd9) ? k_q : (k_q - 5'd9);
  assign pix      = win_q[pix_idx[3:0]];
  assign coef     = tap_coef(k_q);
  assign coef_ext = {{(ACC_W-COEF_W){coef[COEF_W-1]}}, coef};
  assign pix_ext  = {{(ACC_W-DATA_W){1'b0}}, pix};
  assign prod     = coef_ext * pix_ext;
  assign mag      = {1'b0, abs_acc(gx_q)} + {1'b0, abs_acc(gy_q)};

`ifdef SOBEL_SEQ_THRESHOLD_EN
  assign unused_ok = ^{valueA[31:24], valueB[31:16], valueB[7:2]};
`else
  assign unused_ok = ^{valueA[31:24], valueB[31:8], valueB[7:2]};
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    k_d     = k_q;
    done_d  = 1'b0;
    res_d   = 32'd0;
`ifdef SOBEL_SEQ_THRESHOLD_EN
    thr_d   = thr_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Push shifts rows up: row0 is oldest, row2 newest.
          if (cmd[0]) begin
            win_d[2:0] = win_q[5:3];
            win_d[5:3] = win_q[8:6];
            win_d[8:6] = valueA[23:0];
          end
          if (cmd == CMD_CLEAR) begin
            win_d = '0;
          end
          if (cmd == CMD_CLEAR || cmd == CMD_PUSH) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            gx_d    = '0;
            gy_d    = '0;
            k_d     = '0;
            state_d = MAC;
`ifdef SOBEL_SEQ_THRESHOLD_EN
            thr_d   = valueB[15:8];
`endif
          end
        end
      end
      MAC: begin
        if (k_q < 5'd9) gx_d = gx_q + prod;
        else            gy_d = gy_q + prod;
        if (k_q == 5'd17) begin
          k_d     = '0;
          state_d = FINAL;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      FINAL: begin
`ifdef SOBEL_SEQ_THRESHOLD_EN
        res_d = (mag >= {9'd0, thr_q}) ? 32'd255 : 32'd0;
`else
        res_d = {24'd0, sat_u8(mag)};
`endif
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      res_q   <= 32'd0;
`ifdef SOBEL_SEQ_THRESHOLD_EN
      thr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      k_q     <= k_d;
      done_q  <= done_d;
      res_q   <= res_d;
`ifdef SOBEL_SEQ_THRESHOLD_EN
      thr_q   <= thr_d;
`endif
    end
  end

  assign done   = done_q;
  assign result = res_q;

endmodule
